// File: rtl/key_event_gen_if.sv
// Event stream interface between key_event_gen and its consumer.
//   evt_valid : head of the event FIFO holds an event
//   evt_ready : consumer accepts the head when evt_valid & evt_ready
//   evt_data  : {type[1:0], key_idx[2:0]}
//               type 00 CLICK, 01 LONG, 10 REPEAT, 11 LONG_REL
interface key_event_gen_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [4:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: converts debounced, active-low key levels into discrete
// click / long-press / long-release (and optional auto-repeat) events,
// arbitrated by lowest key index into a small valid/ready event FIFO.
// Optional feature macro: KEY_REPEAT_EN (emit REPEAT events while held long).
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   keys_stable debounced keys, active-low (1 = released)
//   evt         event stream (master side): evt_valid, evt_ready, evt_data
//   drop_cnt    saturating count of events lost to pending-slot overwrite
module key_event_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned KEY_CNT    = 8,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned REPEAT_MS  = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_CNT-1:0]  keys_stable,
  key_event_gen_if.master     evt,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned TICK_MAX = CLK_FREQ / 1000 - 1;
  localparam int unsigned PRESC_W  = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int unsigned HOLD_W   = 16;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  localparam logic [1:0] EV_CLICK  = 2'b00;
  localparam logic [1:0] EV_LONG   = 2'b01;
  localparam logic [1:0] EV_REPEAT = 2'b10;
  localparam logic [1:0] EV_LREL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_t;

  // Elaboration-time parameter sanity
  if (LONG_MS < 1 || LONG_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_ms
    $error("key_event_gen: LONG_MS/REPEAT_MS must be in 1..65535");
  end
  if (KEY_CNT < 1 || KEY_CNT > 8) begin : g_bad_keys
    $error("key_event_gen: KEY_CNT must be in 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_gen: FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------- 1 ms tick
  logic [PRESC_W-1:0] presc_q;
  logic               tick_c;

  assign tick_c = (presc_q == PRESC_W'(TICK_MAX));

  always_ff @(posedge clk) begin
    if (rst || tick_c) presc_q <= '0;
    else               presc_q <= presc_q + PRESC_W'(1);
  end

  // ---------------------------------------------------------------- per-key FSMs
  key_state_t          state_q [KEY_CNT];
  key_state_t          state_d [KEY_CNT];
  logic [HOLD_W-1:0]   hold_q  [KEY_CNT];
  logic [HOLD_W-1:0]   hold_d  [KEY_CNT];
  logic [KEY_CNT-1:0]  ev_c;
  logic [1:0]          ev_type_c [KEY_CNT];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(KEY_CNT); i++) begin
      if (rst) begin
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  // Release has priority over a tick in the same cycle
  always_comb begin
    ev_c = '0;
    for (int i = 0; i < int'(KEY_CNT); i++) begin
      state_d[i]   = state_q[i];
      hold_d[i]    = hold_q[i];
      ev_type_c[i] = EV_CLICK;
      case (state_q[i])
        ST_IDLE: begin
          if (!keys_stable[i]) begin
            state_d[i] = ST_PRESSED;
            hold_d[i]  = '0;
          end
        end
        ST_PRESSED: begin
          if (keys_stable[i]) begin
            state_d[i]   = ST_IDLE;
            hold_d[i]    = '0;
            ev_c[i]      = 1'b1;
            ev_type_c[i] = EV_CLICK;
          end else if (tick_c) begin
            if (hold_q[i] == HOLD_W'(LONG_MS - 1)) begin
              state_d[i]   = ST_LONG;
              hold_d[i]    = '0;
              ev_c[i]      = 1'b1;
              ev_type_c[i] = EV_LONG;
            end else begin
              hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
          end
        end
        ST_LONG: begin
          if (keys_stable[i]) begin
            state_d[i]   = ST_IDLE;
            hold_d[i]    = '0;
            ev_c[i]      = 1'b1;
            ev_type_c[i] = EV_LREL;
          end
`ifdef KEY_REPEAT_EN
          else if (tick_c) begin
            if (hold_q[i] == HOLD_W'(REPEAT_MS - 1)) begin
              hold_d[i]    = '0;
              ev_c[i]      = 1'b1;
              ev_type_c[i] = EV_REPEAT;
            end else begin
              hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
          end
`endif
        end
        default: begin
          state_d[i] = ST_IDLE;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- pending slots + arbiter
  logic [KEY_CNT-1:0] pend_v_q;
  logic [KEY_CNT-1:0] pend_v_d;
  logic [1:0]         pend_t_q [KEY_CNT];
  logic [1:0]         pend_t_d [KEY_CNT];
  logic               grant_any_c;
  logic [2:0]         grant_idx_c;
  logic [1:0]         grant_type_c;
  logic               pop_c;
  logic               wr_c;
  logic [CNT_W-1:0]   count_q;
  logic [3:0]         drop_n_c;
  logic [8:0]         drop_sum_c;

  assign pop_c = evt.evt_valid & evt.evt_ready;
  // A pop in the same cycle frees room for a write even when full
  assign wr_c  = grant_any_c & ((count_q != CNT_W'(FIFO_DEPTH)) | pop_c);

  // Lowest index wins: scan downward so the last hit is the smallest
  always_comb begin
    grant_any_c  = 1'b0;
    grant_idx_c  = '0;
    grant_type_c = EV_CLICK;
    for (int i = int'(KEY_CNT) - 1; i >= 0; i--) begin
      if (pend_v_q[i]) begin
        grant_any_c  = 1'b1;
        grant_idx_c  = 3'(i);
        grant_type_c = pend_t_q[i];
      end
    end
  end

  // Granted slot clears; a new event refills it, or overwrites a non-granted one (drop)
  always_comb begin
    pend_v_d = pend_v_q;
    drop_n_c = '0;
    for (int i = 0; i < int'(KEY_CNT); i++) begin
      pend_t_d[i] = pend_t_q[i];
      if (wr_c && (grant_idx_c == 3'(i))) pend_v_d[i] = 1'b0;
      if (ev_c[i]) begin
        if (pend_v_d[i]) drop_n_c = drop_n_c + 4'd1;
        pend_v_d[i] = 1'b1;
        pend_t_d[i] = ev_type_c[i];
      end
    end
  end

  assign drop_sum_c = 9'(drop_cnt) + 9'(drop_n_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < int'(KEY_CNT); i++) pend_t_q[i] <= EV_CLICK;
    end else begin
      pend_v_q <= pend_v_d;
      drop_cnt <= (drop_sum_c > 9'd255) ? 8'hFF : drop_sum_c[7:0];
      for (int i = 0; i < int'(KEY_CNT); i++) pend_t_q[i] <= pend_t_d[i];
    end
  end

  // ---------------------------------------------------------------- event FIFO, registered head
  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_inc_c;
  logic [CNT_W-1:0] count_d;
  logic [4:0]       wdata_c;
  logic [4:0]       head_q;
  logic [4:0]       head_d;
  logic             valid_q;

  assign wdata_c      = {grant_type_c, grant_idx_c};
  assign rd_ptr_inc_c = rd_ptr_q + PTR_W'(1);

  always_comb begin
    count_d = count_q;
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next head: bypass the write when it lands in an empty (or emptying) FIFO
  always_comb begin
    head_d = head_q;
    if (wr_c && ((count_q == '0) || (pop_c && (count_q == CNT_W'(1))))) head_d = wdata_c;
    else if (pop_c)                                                      head_d = mem_q[rd_ptr_inc_c];
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= wdata_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) rd_ptr_q <= rd_ptr_inc_c;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      head_q  <= head_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = head_q;

endmodule
